// File: rtl/csi_tx_pkt_sequencer.sv
// Byte-domain sequencer between pix2byte and csi_tx: queues frame/line events and
// turns them into ordered FS/FE short packets and RAW10 long packets with HS handshake.
module csi_tx_pkt_sequencer #(
    parameter logic [15:0] WC_LINE    = 16'd320,
    parameter logic [5:0]  DT_PIXEL   = 6'h2B,
    parameter logic [1:0]  VC         = 2'b00,
    parameter int          FIFO_DEPTH = 4,
    parameter int          TRAIL_CYC  = 8,
    parameter int          HS_TIMEOUT = 1023
) (
    input  logic        hf_clk90,
    input  logic        reset_n_byte,
    input  logic        enable_i,
    input  logic        fv_start_i,
    input  logic        fv_end_i,
    input  logic        lv_start_i,
    input  logic        byte_en_i,
    input  logic        hs_rdy_i,
    output logic        hs_en_o,
    output logic        sp_en_o,
    output logic        lp_en_o,
    output logic [5:0]  dt_o,
    output logic [15:0] wc_o,
    output logic [1:0]  vc_o,
    output logic        busy_o,
    output logic [15:0] frame_count_o,
    output logic [15:0] line_count_o,
    input  logic        err_clear_i,
    output logic        err_ovf_o,
    output logic        err_seq_o,
    output logic        err_len_o,
    output logic        err_tmo_o
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int TW  = $clog2(HS_TIMEOUT + 1);
    localparam int TRW = $clog2(TRAIL_CYC + 1);
    localparam logic [TW-1:0]  TMO_LAST   = TW'(HS_TIMEOUT - 1);
    localparam logic [TRW-1:0] TRAIL_LAST = TRW'(TRAIL_CYC - 1);

    typedef enum logic [1:0] {EV_FS, EV_FE, EV_LS} ev_t;
    typedef enum logic [2:0] {IDLE, HS_REQ, SP, LP_HDR, LP_PAY, TRAIL} state_t;

    state_t         state;
    ev_t            cur_ev;
    ev_t            fifo_q [FIFO_DEPTH];
    logic [AW:0]    wr_ptr, rd_ptr;
    logic           full, empty, push_req, push, pop, cap_seq, cap_ovf;
    ev_t            push_ev, head;
    logic           in_frame;
    logic [TW-1:0]  tmo_cnt;
    logic [TRW-1:0] trail_cnt;
    logic [15:0]    byte_cnt;

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head   = fifo_q[rd_ptr[AW-1:0]];
    assign pop    = (state == IDLE) && !empty;
    assign push   = push_req && !full;
    assign cap_ovf = push_req && full;
    assign busy_o = (state != IDLE) || !empty;
    assign vc_o   = VC;

    // One event per cycle; anything of lower priority in the same cycle is an ordering error.
    always_comb begin
        push_req = 1'b0;
        push_ev  = EV_LS;
        cap_seq  = 1'b0;
        if (enable_i) begin
            if (fv_end_i) begin
                push_req = 1'b1;
                push_ev  = EV_FE;
                cap_seq  = fv_start_i || lv_start_i;
            end else if (fv_start_i) begin
                push_req = 1'b1;
                push_ev  = EV_FS;
                cap_seq  = lv_start_i;
            end else if (lv_start_i) begin
                push_req = 1'b1;
                push_ev  = EV_LS;
            end
        end
    end

    always_ff @(posedge hf_clk90) begin
        if (push) fifo_q[wr_ptr[AW-1:0]] <= push_ev;
    end

    always_ff @(posedge hf_clk90 or negedge reset_n_byte) begin
        if (!reset_n_byte) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge hf_clk90 or negedge reset_n_byte) begin
        if (!reset_n_byte) begin
            state         <= IDLE;
            cur_ev        <= EV_FS;
            in_frame      <= 1'b0;
            hs_en_o       <= 1'b0;
            sp_en_o       <= 1'b0;
            lp_en_o       <= 1'b0;
            dt_o          <= '0;
            wc_o          <= '0;
            frame_count_o <= '0;
            line_count_o  <= '0;
            tmo_cnt       <= '0;
            trail_cnt     <= '0;
            byte_cnt      <= '0;
            err_ovf_o     <= 1'b0;
            err_seq_o     <= 1'b0;
            err_len_o     <= 1'b0;
            err_tmo_o     <= 1'b0;
        end else begin
            sp_en_o <= 1'b0;
            lp_en_o <= 1'b0;
            // Clear first so an error raised in the same cycle keeps its flag set.
            if (err_clear_i) begin
                err_ovf_o <= 1'b0;
                err_seq_o <= 1'b0;
                err_len_o <= 1'b0;
                err_tmo_o <= 1'b0;
            end
            if (cap_ovf) err_ovf_o <= 1'b1;
            if (cap_seq) err_seq_o <= 1'b1;
            if (byte_en_i && state != LP_PAY) err_len_o <= 1'b1;

            case (state)
                IDLE: if (pop) begin
                    if ((head == EV_LS || head == EV_FE) && !in_frame) begin
                        err_seq_o <= 1'b1;
                    end else begin
                        if (head == EV_FS && in_frame) err_seq_o <= 1'b1;
                        cur_ev  <= head;
                        state   <= HS_REQ;
                        hs_en_o <= 1'b1;
                        tmo_cnt <= '0;
                        case (head)
                            EV_FS:   begin dt_o <= 6'h00;    wc_o <= 16'd0;   end
                            EV_FE:   begin dt_o <= 6'h01;    wc_o <= 16'd0;   end
                            default: begin dt_o <= DT_PIXEL; wc_o <= WC_LINE; end
                        endcase
                    end
                end
                HS_REQ: begin
                    if (hs_rdy_i) begin
                        if (cur_ev == EV_LS) begin
                            state   <= LP_HDR;
                            lp_en_o <= 1'b1;
                        end else begin
                            state   <= SP;
                            sp_en_o <= 1'b1;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        err_tmo_o <= 1'b1;
                        hs_en_o   <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                SP: begin
                    if (cur_ev == EV_FS) begin
                        frame_count_o <= frame_count_o + 16'd1;
                        line_count_o  <= '0;
                        in_frame      <= 1'b1;
                    end else begin
                        in_frame <= 1'b0;
                    end
                    trail_cnt <= '0;
                    state     <= TRAIL;
                end
                LP_HDR: begin
                    byte_cnt <= '0;
                    tmo_cnt  <= '0;
                    state    <= LP_PAY;
                end
                LP_PAY: begin
                    if (byte_en_i) begin
                        tmo_cnt <= '0;
                        if (byte_cnt == WC_LINE - 16'd1) begin
                            if (line_count_o != 16'hFFFF) line_count_o <= line_count_o + 16'd1;
                            trail_cnt <= '0;
                            state     <= TRAIL;
                        end else begin
                            byte_cnt <= byte_cnt + 16'd1;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        err_len_o <= 1'b1;
                        trail_cnt <= '0;
                        state     <= TRAIL;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                TRAIL: begin
                    if (trail_cnt == TRAIL_LAST) begin
                        hs_en_o <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        trail_cnt <= trail_cnt + 1'b1;
                    end
                end
                default: begin
                    hs_en_o <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
